irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller that sits directly upstream of the datapath's trap logic: it takes the timer overflow pulse and the asynchronous external interrupt line, synchronizes and edge-detects the external source, latches both as pending, and presents one prioritized cause code on `interrupt[3:0]`. The code is held until the datapath acknowledges trap entry, and no new request is issued until the handler returns via `mret`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `ext_inter`, minimum 2.
- `CNT_W`, default 8: width of the saturating per-source lost-event counters.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset. Asynchronous, active-low: 0 resets all state immediately.
- `ext_inter`  in  1  external interrupt, asynchronous level; the rising edge is the event.
- `timer_ovf`  in  1  timer overflow, synchronous one-cycle pulse.
- `irq_en`  in  1  global enable (machine interrupt enable from CSR).
- `irq_mask`  in  2  per-source enable: bit0 = timer, bit1 = external.
- `irq_ack`  in  1  one-cycle pulse from the datapath when the trap is taken.
- `is_mret`  in  1  one-cycle pulse when `mret` retires.
- `interrupt`  out  4  cause code: 0000 none, 0001 timer, 0010 external.
- `irq_pending`  out  2  pending bits, {ext, timer}.
- `irq_busy`  out  1  high while in SERVICE.
- `lost_timer`, `lost_ext`  out  CNT_W  saturating counts of coalesced events.

## Operation
- **Event generation**
  - Timer event = `timer_ovf`.
  - External event = rising edge of the synchronized `ext_inter` (last sync stage is high, the previous sample was low).
- **Pending bits**
  - A pending bit is set on its source's event.
  - It is cleared only on `irq_ack` for the source currently being requested.
  - If set and clear occur in the same cycle, set wins and the bit stays 1.
  - An event arriving while its bit is already 1 is coalesced and increments that source's lost counter, which saturates at all-ones.
- **Eligibility:** `pending & irq_mask`, gated by `irq_en`.
- **Priority:** timer over external; both eligible → 0001.
- **State machine**
  - IDLE → REQ when any source is eligible. The winning code is latched into `interrupt`.
  - REQ:
    - `irq_ack` → SERVICE. Clear the latched source's pending bit; `interrupt` = 0000.
    - `irq_en` = 0, or the latched source becomes masked → IDLE. `interrupt` = 0000; the pending bit is kept.
    - `interrupt` stays stable while in REQ, even if a higher-priority source becomes pending.
  - SERVICE: `is_mret` → IDLE. Events are still latched as pending during SERVICE, but no request is issued.
- `irq_ack` outside REQ and `is_mret` outside SERVICE are ignored.
- **Reset values:** `interrupt` = 0000, `irq_pending` = 00, `irq_busy` = 0, both lost counters = 0, state = IDLE, synchronizer and edge flops = 0.
  - If `ext_inter` is already high when reset releases, this counts as a rising edge and produces one event.
  - Reset asserted mid-request or mid-service clears all of the above at once; the pending request is lost.

## Timing
- **Timer path:** `timer_ovf` high in cycle t → pending bit set after edge t+1 → `interrupt` = 0001 after edge t+2. Latency 2.
- **External path (SYNC_STAGES = 2):** `ext_inter` first sampled high at edge k → synchronizer output high after edge k+1 → pending set after edge k+2 → `interrupt` = 0010 after edge k+3.
- **Acknowledge:** `irq_ack` at edge a → `interrupt` = 0000, `irq_busy` = 1, and the pending bit cleared, all after edge a.
- **Return:** `is_mret` at edge m → IDLE after edge m. A source that is still pending re-requests after edge m+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `irq_pkg`:
  - state enum {IDLE, REQ, SERVICE}
  - cause constants IRQ_NONE = 4'b0000, IRQ_TIMER = 4'b0001, IRQ_EXT = 4'b0010
  - source index constants SRC_TIMER = 0, SRC_EXT = 1
- Sub-module `sync_edge`: parameterized SYNC_STAGES synchronizer plus rising-edge pulse output, with the same async active-low reset.
- Top level: pending logic, lost counters, priority encode, FSM.

## Test plan
- Reset with `ext_inter` = 0; pulse `timer_ovf` at cycle 5 with `irq_en` = 1 and `irq_mask` = 11 → `interrupt` = 0001 after edge 7; `irq_ack` at edge 9 → `interrupt` = 0000, `irq_busy` = 1; `is_mret` → `irq_busy` = 0.
- Raise `ext_inter` asynchronously → `interrupt` = 0010 exactly 3 edges after first sample; hold it high → no second request after `is_mret`.
- Timer and external events in the same cycle → request 0001 first; after ack and mret, request 0010.
- Three `timer_ovf` pulses while timer is pending and unacked → `lost_timer` = 2; drive 300 coalesced events → saturates at 255.
- During REQ, drop `irq_en` → `interrupt` = 0000 next edge with the pending bit kept; restore `irq_en` → same code re-requested; `irq_ack` in the same cycle as a new timer pulse → bit stays 1.
- Assert `rst` = 0 mid-SERVICE, off-clock-edge → all outputs at reset values immediately; release with `ext_inter` high → one external event.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
//  Module  : irq_pkg
//  Brief   : Shared types and constants for the interrupt controller.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [3:0] IRQ_NONE  = 4'b0000;
  localparam logic [3:0] IRQ_TIMER = 4'b0001;
  localparam logic [3:0] IRQ_EXT   = 4'b0010;

  localparam int SRC_TIMER = 0;
  localparam int SRC_EXT   = 1;
  localparam int NUM_SRC   = 2;

  function automatic logic [3:0] src_to_cause(input logic src);
    return (src == 1'(SRC_EXT)) ? IRQ_EXT : IRQ_TIMER;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_if.sv
// ============================================================================
//  Module  : irq_ctrl_if
//  Brief   : Datapath <-> interrupt controller request/acknowledge bundle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface irq_ctrl_if;
  import irq_pkg::*;

  logic                irq_en;
  logic [NUM_SRC-1:0]  irq_mask;
  logic                irq_ack;
  logic                is_mret;
  logic [3:0]          interrupt;
  logic [NUM_SRC-1:0]  irq_pending;
  logic                irq_busy;

  // master = datapath / CSR side, slave = interrupt controller
  modport master (
    output irq_en, irq_mask, irq_ack, is_mret,
    input  interrupt, irq_pending, irq_busy
  );

  modport slave (
    input  irq_en, irq_mask, irq_ack, is_mret,
    output interrupt, irq_pending, irq_busy
  );

endinterface

`default_nettype wire

// File: rtl/irq_ctrl_sync_edge.sv
// ============================================================================
//  Module  : sync_edge
//  Brief   : Multi-flop synchronizer with rising-edge pulse (SYNC_STAGES >= 2).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_async,
  output logic      o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Pulse depends only on flops, so a line high at reset release yields one event
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
//  Module  : irq_ctrl
//  Brief   : Two-source prioritized interrupt controller (timer > external).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module irq_ctrl
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         ext_inter,
  input  wire logic         timer_ovf,
  irq_ctrl_if.slave         bus,
  output logic [CNT_W-1:0]  lost_timer,
  output logic [CNT_W-1:0]  lost_ext
);

  logic               w_ext_rise;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] r_pending;
  logic               w_ack_take;
  logic               w_win_src;

  irq_state_e         r_state;
  irq_state_e         w_state_nxt;
  logic               r_src;
  logic               w_src_nxt;
  logic [3:0]         r_interrupt;
  logic [3:0]         w_interrupt_nxt;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (ext_inter),
    .o_rise  (w_ext_rise)
  );

  assign w_set      = {w_ext_rise, timer_ovf};
  assign w_ack_take = (r_state == REQ) && bus.irq_ack;

  always_comb begin
    w_clr = '0;
    if (w_ack_take) begin
      w_clr[r_src] = 1'b1;
    end
  end

  // Set has priority over the acknowledge clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lost
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_set[i] && r_pending[i] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign lost_timer = g_lost[SRC_TIMER].r_cnt;
  assign lost_ext   = g_lost[SRC_EXT].r_cnt;

  assign w_elig    = r_pending & bus.irq_mask & {NUM_SRC{bus.irq_en}};
  assign w_win_src = w_elig[SRC_TIMER] ? 1'(SRC_TIMER) : 1'(SRC_EXT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_src       <= 1'b0;
      r_interrupt <= IRQ_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_src       <= w_src_nxt;
      r_interrupt <= w_interrupt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_interrupt_nxt = r_interrupt;
    case (r_state)
      IDLE: begin
        w_interrupt_nxt = IRQ_NONE;
        if (|w_elig) begin
          w_state_nxt     = REQ;
          w_src_nxt       = w_win_src;
          w_interrupt_nxt = src_to_cause(w_win_src);
        end
      end
      REQ: begin
        // Code is frozen here; a later higher-priority event waits its turn
        if (bus.irq_ack) begin
          w_state_nxt     = SERVICE;
          w_interrupt_nxt = IRQ_NONE;
        end else if (!bus.irq_en || !bus.irq_mask[r_src]) begin
          w_state_nxt     = IDLE;
          w_interrupt_nxt = IRQ_NONE;
        end
      end
      SERVICE: begin
        w_interrupt_nxt = IRQ_NONE;
        if (bus.is_mret) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_interrupt_nxt = IRQ_NONE;
      end
    endcase
  end

  assign bus.interrupt   = r_interrupt;
  assign bus.irq_pending = r_pending;
  assign bus.irq_busy    = (r_state == SERVICE);

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  Module  : tb_irq_ctrl
//  Brief   : Scoreboard bench for irq_ctrl: expected causes queued at stimulus.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;
  import irq_pkg::*;

  localparam int CNT_W = 8;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             ext_inter = 1'b0;
  logic             timer_ovf = 1'b0;
  logic [CNT_W-1:0] lost_timer;
  logic [CNT_W-1:0] lost_ext;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ext_inter  (ext_inter),
    .timer_ovf  (timer_ovf),
    .bus        (bus),
    .lost_timer (lost_timer),
    .lost_ext   (lost_ext)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst           = 1'b0;
    ext_inter     = 1'b0;
    timer_ovf     = 1'b0;
    bus.irq_en    = 1'b1;
    bus.irq_mask  = 2'b11;
    bus.irq_ack   = 1'b0;
    bus.is_mret   = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Counts edges until a request appears; lat = -1 when the budget expires
  task automatic wait_req(input int budget, output logic [3:0] code, output int lat);
    code = IRQ_NONE;
    lat  = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.interrupt !== IRQ_NONE) begin
        code = bus.interrupt;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic pop_exp(output logic [3:0] exp);
    if (sb.size() > 0) exp = sb.pop_front();
    else               exp = 4'hF;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({bus.interrupt, bus.irq_pending, bus.irq_busy, lost_timer, lost_ext} !== '0) begin
      n_err++;
      $display("FAIL reset_vals: got int=%b pend=%b busy=%b lt=%0d le=%0d want all zero",
               bus.interrupt, bus.irq_pending, bus.irq_busy, lost_timer, lost_ext);
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.interrupt !== IRQ_NONE || bus.irq_pending !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: got int=%b pend=%b want 0000/00", bus.interrupt, bus.irq_pending);
    end
  endtask

  task automatic test_timer();
    logic [3:0] code, exp;
    int         lat;
    apply_reset();
    tick();
    timer_ovf = 1'b1;
    sb.push_back(IRQ_TIMER);
    tick();
    timer_ovf = 1'b0;
    n_cmp++;
    if (bus.irq_pending !== 2'b01 || bus.interrupt !== IRQ_NONE) begin
      n_err++;
      $display("FAIL timer_pend: got pend=%b int=%b want 01/0000", bus.irq_pending, bus.interrupt);
    end
    // second edge after the pulse
    wait_req(8, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 1) begin
      n_err++;
      $display("FAIL timer_req: got code=%b lat=%0d want code=%b lat=1", code, lat, exp);
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.interrupt !== IRQ_TIMER || bus.irq_busy !== 1'b0) begin
      n_err++;
      $display("FAIL timer_hold: got int=%b busy=%b want 0001/0", bus.interrupt, bus.irq_busy);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_cmp++;
    if (bus.interrupt !== IRQ_NONE || bus.irq_busy !== 1'b1 || bus.irq_pending !== 2'b00) begin
      n_err++;
      $display("FAIL timer_ack: got int=%b busy=%b pend=%b want 0000/1/00",
               bus.interrupt, bus.irq_busy, bus.irq_pending);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_cmp++;
    if (bus.irq_busy !== 1'b1) begin
      n_err++;
      $display("FAIL ack_in_service: got busy=%b want 1", bus.irq_busy);
    end
    bus.is_mret = 1'b1;
    tick();
    bus.is_mret = 1'b0;
    n_cmp++;
    if (bus.irq_busy !== 1'b0 || bus.interrupt !== IRQ_NONE) begin
      n_err++;
      $display("FAIL timer_mret: got busy=%b int=%b want 0/0000", bus.irq_busy, bus.interrupt);
    end
  endtask

  task automatic test_ext();
    logic [3:0] code, exp;
    int         lat;
    bit         seen;
    apply_reset();
    tick();
    #3 ext_inter = 1'b1;
    sb.push_back(IRQ_EXT);
    // first sample edge counts as 1, request visible after the 4th edge
    wait_req(10, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 4) begin
      n_err++;
      $display("FAIL ext_req: got code=%b lat=%0d want code=%b lat=4", code, lat, exp);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.is_mret = 1'b1;
    tick();
    bus.is_mret = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.interrupt !== IRQ_NONE || bus.irq_pending !== 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (seen || lost_ext !== '0) begin
      n_err++;
      $display("FAIL ext_level_once: got rerequest=%0d lost_ext=%0d want 0/0", seen, lost_ext);
    end
    ext_inter = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] code, exp;
    int         lat;
    apply_reset();
    tick();
    ext_inter = 1'b1;
    tick();
    tick();
    timer_ovf = 1'b1;
    sb.push_back(IRQ_TIMER);
    sb.push_back(IRQ_EXT);
    tick();
    timer_ovf = 1'b0;
    n_cmp++;
    if (bus.irq_pending !== 2'b11) begin
      n_err++;
      $display("FAIL both_pend: got pend=%b want 11", bus.irq_pending);
    end
    wait_req(6, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 1) begin
      n_err++;
      $display("FAIL both_first: got code=%b lat=%0d want code=%b lat=1", code, lat, exp);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_cmp++;
    if (bus.irq_pending !== 2'b10 || bus.interrupt !== IRQ_NONE) begin
      n_err++;
      $display("FAIL both_ack: got pend=%b int=%b want 10/0000", bus.irq_pending, bus.interrupt);
    end
    bus.is_mret = 1'b1;
    tick();
    bus.is_mret = 1'b0;
    wait_req(6, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 1) begin
      n_err++;
      $display("FAIL both_second: got code=%b lat=%0d want code=%b lat=1", code, lat, exp);
    end
    ext_inter = 1'b0;
  endtask

  task automatic test_lost();
    logic [3:0] code, exp;
    int         lat;
    int         exp_lost;
    apply_reset();
    tick();
    sb.push_back(IRQ_TIMER);
    timer_ovf = 1'b1;
    repeat (3) tick();
    timer_ovf = 1'b0;
    n_cmp++;
    if (lost_timer !== CNT_W'(2)) begin
      n_err++;
      $display("FAIL lost_three: got lost_timer=%0d want 2", lost_timer);
    end
    wait_req(4, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp) begin
      n_err++;
      $display("FAIL lost_req: got code=%b want %b", code, exp);
    end
    timer_ovf = 1'b1;
    repeat (300) tick();
    timer_ovf = 1'b0;
    exp_lost = (2 + 300 > 255) ? 255 : 2 + 300;
    n_cmp++;
    if (lost_timer !== CNT_W'(exp_lost) || lost_ext !== '0) begin
      n_err++;
      $display("FAIL lost_sat: got lost_timer=%0d lost_ext=%0d want %0d/0", lost_timer, lost_ext, exp_lost);
    end
  endtask

  task automatic test_en_drop();
    logic [3:0] code, exp;
    int         lat;
    apply_reset();
    tick();
    sb.push_back(IRQ_TIMER);
    timer_ovf = 1'b1;
    tick();
    timer_ovf = 1'b0;
    wait_req(4, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp) begin
      n_err++;
      $display("FAIL en_first: got code=%b want %b", code, exp);
    end
    bus.irq_en = 1'b0;
    tick();
    n_cmp++;
    if (bus.interrupt !== IRQ_NONE || bus.irq_pending !== 2'b01 || bus.irq_busy !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop: got int=%b pend=%b busy=%b want 0000/01/0",
               bus.interrupt, bus.irq_pending, bus.irq_busy);
    end
    tick();
    bus.irq_en = 1'b1;
    sb.push_back(IRQ_TIMER);
    wait_req(4, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 1) begin
      n_err++;
      $display("FAIL en_restore: got code=%b lat=%0d want code=%b lat=1", code, lat, exp);
    end
    bus.irq_mask = 2'b10;
    tick();
    n_cmp++;
    if (bus.interrupt !== IRQ_NONE || bus.irq_pending !== 2'b01) begin
      n_err++;
      $display("FAIL mask_drop: got int=%b pend=%b want 0000/01", bus.interrupt, bus.irq_pending);
    end
    bus.irq_mask = 2'b11;
    sb.push_back(IRQ_TIMER);
    wait_req(4, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 1) begin
      n_err++;
      $display("FAIL mask_restore: got code=%b lat=%0d want code=%b lat=1", code, lat, exp);
    end
    bus.irq_ack = 1'b1;
    timer_ovf   = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    timer_ovf   = 1'b0;
    n_cmp++;
    if (bus.irq_pending !== 2'b01 || bus.irq_busy !== 1'b1 || bus.interrupt !== IRQ_NONE) begin
      n_err++;
      $display("FAIL ack_set_same: got pend=%b busy=%b int=%b want 01/1/0000",
               bus.irq_pending, bus.irq_busy, bus.interrupt);
    end
    bus.is_mret = 1'b1;
    tick();
    bus.is_mret = 1'b0;
    sb.push_back(IRQ_TIMER);
    wait_req(4, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 1) begin
      n_err++;
      $display("FAIL mret_rereq: got code=%b lat=%0d want code=%b lat=1", code, lat, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] code, exp;
    int         lat;
    bit         seen;
    apply_reset();
    tick();
    timer_ovf = 1'b1;
    repeat (2) tick();
    timer_ovf = 1'b0;
    tick();
    sb.push_back(IRQ_TIMER);
    wait_req(4, code, lat);
    pop_exp(exp);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    n_cmp++;
    if (code !== exp || bus.irq_busy !== 1'b1 || lost_timer !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL pre_reset: got code=%b busy=%b lost_timer=%0d want %b/1/1",
               code, bus.irq_busy, lost_timer, exp);
    end
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.interrupt, bus.irq_pending, bus.irq_busy, lost_timer, lost_ext} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got int=%b pend=%b busy=%b lt=%0d le=%0d want all zero",
               bus.interrupt, bus.irq_pending, bus.irq_busy, lost_timer, lost_ext);
    end
    ext_inter = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    sb.push_back(IRQ_EXT);
    wait_req(10, code, lat);
    pop_exp(exp);
    n_cmp++;
    if (code !== exp || lat != 4) begin
      n_err++;
      $display("FAIL release_high: got code=%b lat=%0d want code=%b lat=4", code, lat, exp);
    end
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    bus.is_mret = 1'b1;
    tick();
    bus.is_mret = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.interrupt !== IRQ_NONE) seen = 1'b1;
    end
    n_cmp++;
    if (seen || lost_ext !== '0) begin
      n_err++;
      $display("FAIL release_once: got rerequest=%0d lost_ext=%0d want 0/0", seen, lost_ext);
    end
    ext_inter = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timer();
    test_ext();
    test_simultaneous();
    test_lost();
    test_en_drop();
    test_async_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
